// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused; the FSM steers it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// 1-bit full adder cell, shared across the team's arithmetic blocks.
module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes one bit pair per
// clock, LSB first, with the carry held in a flip-flop between bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; S/Cout hold the last result
// ST_SHIFT | one bit pair per cycle through fa, busy=1
// ST_DONE  | one-cycle done pulse; start here chains the next addition
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   s_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_bit;
  logic               fa_s;
  logic               fa_cout;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fa u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, status outputs and start acceptance.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = ST_SHIFT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting, and result update on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == ST_SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + CNT_W'(1);
      // Publish the finished sum together with the move into ST_DONE so the
      // visible result never shows partial bits.
      if (last_bit) begin
        S    <= {fa_s, s_sr[WIDTH-1:1]};
        Cout <= fa_cout;
      end
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a plain-arithmetic
// reference model and randomized operands.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         cout;

  int total;
  int passed;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (s_out),
    .Cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {Cout,S} = A + B + Cin as unsigned arithmetic.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int unsigned r;
    r = int'(a) + int'(b) + (c ? 1 : 0);
    return r[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble inputs.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom_range(1, 0));
  endtask

  // Returns the 1-based cycle (counted from the current one) where done is
  // seen, or -1 on timeout; also counts busy cycles before it.
  task automatic wait_done(output int cyc, output int busy_cycles);
    cyc = -1;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done === 1'b1) begin
        cyc = i;
        return;
      end
      if (busy === 1'b1) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    int act;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (s_out !== 8'h00) $display("FAIL reset_s got %h want 00", s_out); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) act++;
    end
    total++; if (act !== 0) $display("FAIL idle_no_activity got %0d active cycles want 0", act); else passed++;
  endtask

  task automatic test_basic();
    int cyc, bc;
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done(cyc, bc);
    total++; if (cyc !== 9) $display("FAIL basic_latency got %0d want 9", cyc); else passed++;
    total++; if (bc !== 8) $display("FAIL basic_busy_cycles got %0d want 8", bc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done got %b want 0", busy); else passed++;
    total++; if (s_out !== 8'h96) $display("FAIL basic_sum got %h want 96", s_out); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL basic_cout got %b want 0", cout); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
    total++; if (s_out !== 8'h96) $display("FAIL basic_sum_hold got %h want 96", s_out); else passed++;
    tick();
  endtask

  task automatic test_carry();
    int cyc, bc;
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, bc);
    total++; if (cyc !== 9) $display("FAIL carry1_latency got %0d want 9", cyc); else passed++;
    total++; if ({cout, s_out} !== 9'h100) $display("FAIL carry1_result got %b_%h want 1_00", cout, s_out); else passed++;
    tick();
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(cyc, bc);
    total++; if (cyc !== 9) $display("FAIL carry2_latency got %0d want 9", cyc); else passed++;
    total++; if ({cout, s_out} !== 9'h1FF) $display("FAIL carry2_result got %b_%h want 1_ff", cout, s_out); else passed++;
    tick();
  endtask

  task automatic test_random();
    int cyc, bc;
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] exp;
    for (int n = 0; n < 20; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(1, 0));
      exp = ref_add(a, b, c);
      launch(a, b, c);
      wait_done(cyc, bc);
      total++; if (cyc !== 9) $display("FAIL rand_latency[%0d] got %0d want 9", n, cyc); else passed++;
      total++;
      if ({cout, s_out} !== exp)
        $display("FAIL rand_result[%0d] a=%h b=%h cin=%b got %b_%h want %b_%h", n, a, b, c,
                 cout, s_out, exp[W], exp[W-1:0]);
      else passed++;
      repeat ($urandom_range(3, 1)) tick();
    end
  endtask

  task automatic test_start_during_busy();
    int cyc, bc, extra;
    launch(8'h10, 8'h20, 1'b0);       // now in cycle 1
    repeat (3) tick();                // cycle 4
    start = 1'b1;
    a_in  = 8'hFF;
    tick();                           // cycle 5
    start = 1'b0;
    wait_done(cyc, bc);
    total++; if (cyc + 4 !== 9) $display("FAIL busy_start_done_cycle got %0d want 9", cyc + 4); else passed++;
    total++; if ({cout, s_out} !== 9'h030) $display("FAIL busy_start_result got %b_%h want 0_30", cout, s_out); else passed++;
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    total++; if (extra !== 0) $display("FAIL busy_start_second_done got %0d want 0", extra); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    launch(8'h33, 8'h44, 1'b0);
    wait_done(cyc, bc);
    total++; if (cyc !== 9) $display("FAIL b2b_first_latency got %0d want 9", cyc); else passed++;
    total++; if (s_out !== 8'h77) $display("FAIL b2b_first_sum got %h want 77", s_out); else passed++;
    start = 1'b1;                     // held through the done cycle
    a_in  = 8'h01;
    b_in  = 8'h01;
    cin   = 1'b0;
    tick();                           // cycle 1 of second op
    start = 1'b0;
    a_in  = 8'hC3;
    total++; if (busy !== 1'b1) $display("FAIL b2b_restart_busy got %b want 1", busy); else passed++;
    repeat (4) tick();                // cycle 5
    total++; if (s_out !== 8'h77) $display("FAIL b2b_hold_first got %h want 77", s_out); else passed++;
    wait_done(cyc, bc);
    total++; if (cyc + 4 !== 9) $display("FAIL b2b_second_latency got %0d want 9", cyc + 4); else passed++;
    total++; if ({cout, s_out} !== 9'h002) $display("FAIL b2b_second_result got %b_%h want 0_02", cout, s_out); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, seen;
    logic [W-1:0] a, b;
    logic [W:0] exp;
    launch(8'hA5, 8'h7E, 1'b1);       // cycle 1
    repeat (3) tick();                // cycle 4
    #2 rst_n = 1'b0;                  // mid-cycle, away from any edge
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    total++; if ({cout, s_out} !== 9'h000) $display("FAIL midrst_outputs got %b_%h want 0_00", cout, s_out); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_no_done got %0d active cycles want 0", seen); else passed++;
    a = W'($urandom);
    b = W'($urandom);
    exp = ref_add(a, b, 1'b0);
    launch(a, b, 1'b0);
    wait_done(cyc, bc);
    total++; if (cyc !== 9) $display("FAIL midrst_fresh_latency got %0d want 9", cyc); else passed++;
    total++;
    if ({cout, s_out} !== exp)
      $display("FAIL midrst_fresh_result got %b_%h want %b_%h", cout, s_out, exp[W], exp[W-1:0]);
    else passed++;
    tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_during_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_serial_adder
